wb_burst_ram: RTL
=================

WB_BURST_RAM -- requirements
Module: wb_burst_ram

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data width in bits; legal values 32 and 64 only.
REQ-002 SHALL have parameter DEPTH, default 65536, meaning memory size in bytes; power of two, at least 8*DW/8.
REQ-003 SHALL have parameter WAIT_STATES, default 0, meaning extra cycles before the first ack of each cycle; range 0..7.
REQ-004 SHALL have parameter MEMFILE, default "", meaning hex image loaded at time zero when non-empty.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 wb_clk_i  in  1  clock; all logic on rising edge.
REQ-007 wb_rst_ni  in  1  asynchronous active-low reset.
REQ-008 wb_adr_i  in  32  byte address.
REQ-009 wb_dat_i  in  DW  write data.
REQ-010 wb_sel_i  in  DW/8  byte-lane write enables.
REQ-011 wb_we_i  in  1  write when 1, read when 0.
REQ-012 wb_cti_i  in  3  Wishbone B3 cycle type.
REQ-013 wb_bte_i  in  2  burst type: 0 linear, 1 wrap-4, 2 wrap-8, 3 wrap-16.
REQ-014 wb_cyc_i  in  1  bus cycle active.
REQ-015 wb_stb_i  in  1  strobe.
REQ-016 wb_dat_o  out  DW  read data.
REQ-017 wb_ack_o  out  1  transfer acknowledge.
REQ-018 wb_err_o  out  1  transfer error.
REQ-019 burst_o  out  1  high while FSM is in BURST.

Function
REQ-020 SHALL define valid = wb_cyc_i & wb_stb_i, and word index = wb_adr_i >> log2(DW/8).
REQ-021 SHALL implement FSM states IDLE, WAIT, ACK and BURST.
REQ-022 IDLE + valid: SHALL latch the word index, wb_cti_i and wb_bte_i. Next state is WAIT if WAIT_STATES>0, otherwise ACK.
REQ-023 WAIT SHALL count WAIT_STATES cycles, then go to ACK.
REQ-024 ACK SHALL drive wb_ack_o high for one cycle, with wb_dat_o holding the addressed word in that same cycle.
REQ-025 ACK exit for a classic cycle (latched cti 000, 111, or reserved 011..110): next state SHALL be IDLE. Back-to-back classic requests SHALL therefore be acked at most every other cycle with WAIT_STATES=0.
REQ-026 ACK exit for latched cti 001 or 010: next state SHALL be BURST.
REQ-027 BURST SHALL assert wb_ack_o in every cycle in which valid is high, giving one beat per cycle.
REQ-028 A BURST cycle in which valid is low SHALL deassert ack, hold the address, and resume on the next valid.
REQ-029 Next address after each acked beat: cti 001 SHALL keep the address; cti 010 SHALL increment the word index by 1 per bte. Linear increments the full index; wrap-N increments only the low log2(N) bits modulo N, and upper bits are unchanged.
REQ-030 An acked beat with wb_cti_i=111 SHALL end the burst, and the next state SHALL be IDLE.
REQ-031 Writes SHALL commit only on acked beats, per asserted wb_sel_i lane; unselected lanes SHALL be unchanged.
REQ-032 Read data SHALL reflect any write committed in an earlier cycle.
REQ-033 wb_cyc_i low in any non-IDLE state SHALL force IDLE on the next edge, with ack low and no write.
REQ-034 The word index SHALL wrap modulo DEPTH/(DW/8) when error detection is compiled out.

Reset
REQ-035 While wb_rst_ni=0: state SHALL be IDLE, wb_ack_o=0, wb_err_o=0, burst_o=0, wb_dat_o=0, and wait counter=0.
REQ-036 Memory contents SHALL NOT be cleared by reset.
REQ-037 Reset asserted mid-burst SHALL abort it with no further write. After release, the first accept SHALL use a fresh wb_adr_i.

Configuration
REQ-038 Macro WB_BURST_RAM_ERR_EN defined: a beat whose byte address is >= DEPTH SHALL assert wb_err_o instead of wb_ack_o, with no write and wb_dat_o=0. An erroring beat in BURST SHALL return the FSM to IDLE.
REQ-039 Macro WB_BURST_RAM_ERR_EN undefined: wb_err_o SHALL be constant 0 and addresses SHALL wrap per REQ-034.

Verification
REQ-040 Classic: DW=32, WAIT_STATES=0, write 0xDEADBEEF to 0x10 with sel=1111, then read 0x10 -> each ack 1 cycle after valid; read returns 0xDEADBEEF.
REQ-041 Byte lanes: over 0xDEADBEEF at 0x10, write 0x000000AA with sel=0001 -> read 0xDEADBEAA.
REQ-042 Wrap-4 burst: read from 0x0C with cti 010 ×3 then 111, bte=1 -> beats at 0x0C, 0x00, 0x04, 0x08; 4 consecutive acks; burst_o low after the last.
REQ-043 Wait and stall: WAIT_STATES=3, linear burst from 0x40 with stb low for 2 cycles after beat 2 -> first ack 4 cycles after valid; beat 3 at 0x48 after the stall.
REQ-044 Abort: drop wb_cyc_i mid-write-burst -> IDLE next cycle, later beats unwritten; asserting wb_rst_ni=0 mid-burst -> ack low immediately.
REQ-045 Error (WB_BURST_RAM_ERR_EN, DEPTH=65536): write 0x10000 -> err pulse, no ack, word 0 unchanged; same stimulus without the macro -> ack, word 0 written.

Source files
------------

// File: rtl/wb_burst_ram.sv
`default_nettype none
// ============================================================================
// Module   : wb_burst_ram
// Purpose  : Wishbone B3 RAM slave with classic, constant and incrementing
//            (linear / wrap-4/8/16) bursts and optional wait states.
//            Define WB_BURST_RAM_ERR_EN to flag out-of-range beats on wb_err_o.
// Revision : 1.0  initial release
// ============================================================================
module wb_burst_ram #(
    parameter int DW          = 32,
    parameter int DEPTH       = 65536,
    parameter int WAIT_STATES = 0,
    parameter     MEMFILE     = ""
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic [31:0]     wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            burst_o
);

    localparam int c_LANES = DW / 8;
    localparam int c_BW    = $clog2(c_LANES);
    localparam int c_WORDS = DEPTH / c_LANES;
    localparam int c_IW    = $clog2(c_WORDS);
    localparam int c_XW    = 32 - c_BW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ACK   = 2'd2,
        S_BURST = 2'd3
    } state_t;

    state_t          r_state;
    logic [c_XW-1:0] r_idx;
    logic [2:0]      r_cti;
    logic [1:0]      r_bte;
    logic [2:0]      r_wcnt;
    logic [DW-1:0]   r_dat;
    logic [DW-1:0]   r_mem [0:c_WORDS-1];

    logic            w_valid;
    logic            w_beat;
    logic            w_oor;
    logic            w_noor;
    logic            w_wr;
    logic            w_fwd;
    logic [c_XW-1:0] w_nidx;
    logic [DW-1:0]   w_merge;
    logic            w_unused;

    // Wrap-N bursts advance only the low log2(N) index bits.
    function automatic logic [c_XW-1:0] f_next(input logic [c_XW-1:0] idx,
                                               input logic [1:0]      bte);
        logic [c_XW-1:0] m;
        case (bte)
            2'd1:    m = c_XW'(3);
            2'd2:    m = c_XW'(7);
            2'd3:    m = c_XW'(15);
            default: m = '1;
        endcase
        return (idx & ~m) | ((idx + c_XW'(1)) & m);
    endfunction

    assign w_valid  = wb_cyc_i & wb_stb_i;
    assign w_beat   = wb_cyc_i & ((r_state == S_ACK) | ((r_state == S_BURST) & wb_stb_i));
    assign w_unused = &{1'b0, wb_adr_i[c_BW-1:0]};

`ifdef WB_BURST_RAM_ERR_EN
    assign w_oor    = |r_idx[c_XW-1:c_IW];
    assign w_noor   = |w_nidx[c_XW-1:c_IW];
    assign wb_err_o = w_beat & w_oor;
`else
    assign w_oor    = 1'b0;
    assign w_noor   = 1'b0;
    assign wb_err_o = 1'b0;
`endif

    assign wb_ack_o = w_beat & ~w_oor;
    assign w_wr     = wb_ack_o & wb_we_i;
    assign w_fwd    = w_wr & (w_nidx == r_idx);
    assign wb_dat_o = r_dat;
    assign burst_o  = (r_state == S_BURST);

    always_comb begin
        w_merge = r_mem[r_idx[c_IW-1:0]];
        for (int b = 0; b < c_LANES; b++) begin
            if (wb_sel_i[b]) begin
                w_merge[8*b +: 8] = wb_dat_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_nidx = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    w_nidx = wb_adr_i[31:c_BW];
                end
            end
            S_ACK: begin
                if (wb_ack_o && r_cti == 3'b010) begin
                    w_nidx = f_next(r_idx, r_bte);
                end
            end
            S_BURST: begin
                if (wb_ack_o && wb_cti_i == 3'b010) begin
                    w_nidx = f_next(r_idx, r_bte);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_wr) begin
            r_mem[r_idx[c_IW-1:0]] <= w_merge;
        end
    end

    // Read data is prefetched for the index the next cycle will address.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cti   <= 3'b000;
            r_bte   <= 2'b00;
            r_wcnt  <= 3'd0;
            r_dat   <= '0;
        end else begin
            r_idx <= w_nidx;
            r_dat <= w_noor ? '0 : (w_fwd ? w_merge : r_mem[w_nidx[c_IW-1:0]]);
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_cti   <= wb_cti_i;
                        r_bte   <= wb_bte_i;
                        r_wcnt  <= 3'd0;
                        r_state <= (WAIT_STATES > 0) ? S_WAIT : S_ACK;
                    end
                end
                S_WAIT: begin
                    if (!wb_cyc_i) begin
                        r_wcnt  <= 3'd0;
                        r_state <= S_IDLE;
                    end else if (r_wcnt == 3'(WAIT_STATES - 1)) begin
                        r_wcnt  <= 3'd0;
                        r_state <= S_ACK;
                    end else begin
                        r_wcnt  <= r_wcnt + 3'd1;
                    end
                end
                S_ACK: begin
                    if (!wb_cyc_i || w_oor) begin
                        r_state <= S_IDLE;
                    end else if (r_cti == 3'b001 || r_cti == 3'b010) begin
                        r_state <= S_BURST;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BURST: begin
                    if (!wb_cyc_i) begin
                        r_state <= S_IDLE;
                    end else if (wb_stb_i && (w_oor || wb_cti_i == 3'b111)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
